// File: rtl/nios_security_pwm_ctrl_if.sv
// Avalon-MM slave bus bundle for nios_security_pwm_ctrl.
//   address    : word address (4 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : read data, combinational from address (zero wait states)
// master drives the request signals; slave returns readdata.
interface nios_security_pwm_ctrl_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_security_pwm_ctrl.sv
// Multi-channel PWM generator with a Nios-visible register file, double-buffered
// period/duty settings and a duty-write watchdog that forces a failsafe duty.
//
// Ports:
//   clk     : system clock, all state on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   pwm_out : registered PWM outputs, one per channel
//
// Register map (word addresses):
//   0 CTRL     bit0 enable, bit1 wdog_en
//   1 PERIOD   [15:0], reads return the pending value
//   2 PRESCALE [15:0]
//   3 STATUS   bit0 failsafe, bit1 update_pending (read-only)
//   8+i DUTY_i [15:0], reads return the pending value
module nios_security_pwm_ctrl #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned WDOG_CYCLES = 1000000,
  parameter int unsigned FS_DUTY     = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  nios_security_pwm_ctrl_if.slave bus,
  output logic [N_CH-1:0]         pwm_out
);

  localparam int unsigned WdogW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WdogW-1:0] WdogMax = WdogW'(WDOG_CYCLES - 1);
  localparam logic [15:0] FsDuty = 16'(FS_DUTY);

  // Register state
  logic                   enable_q, enable_d;
  logic                   wdog_en_q, wdog_en_d;
  logic [15:0]            period_pend_q, period_pend_d;
  logic [15:0]            period_act_q, period_act_d;
  logic [15:0]            prescale_q, prescale_d;
  logic [N_CH-1:0][15:0]  duty_pend_q, duty_pend_d;
  logic [N_CH-1:0][15:0]  duty_act_q, duty_act_d;
  logic [15:0]            presc_q, presc_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [WdogW-1:0]       wdog_q, wdog_d;
  logic                   failsafe_q, failsafe_d;
  logic                   upd_q, upd_d;
  logic [N_CH-1:0]        pwm_q, pwm_d;

  // Decoded bus writes
  logic            wr;
  logic            wr_ctrl, wr_period, wr_prescale;
  logic [N_CH-1:0] wr_duty;
  logic            duty_wr_any;

  logic tick, wrap, swap, wdog_run;
  logic [N_CH-1:0][15:0] duty_eff;

  // Upper write-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata[31:16];

  always_comb begin
    wr          = bus.chipselect && !bus.write_n;
    wr_ctrl     = wr && (bus.address == 4'd0);
    wr_period   = wr && (bus.address == 4'd1);
    wr_prescale = wr && (bus.address == 4'd2);
    wr_duty     = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_duty[i] = wr && (bus.address == 4'(8 + i));
    end
    duty_wr_any = |wr_duty;
  end

  always_comb begin
    duty_eff = '0;
    for (int i = 0; i < N_CH; i++) begin
      duty_eff[i] = failsafe_q ? FsDuty : duty_act_q[i];
    end
  end

  always_comb begin
    tick     = enable_q && (presc_q == prescale_q);
    // >= keeps the counter bounded even if the active period ever shrank under it
    wrap     = tick && (cnt_q >= period_act_q);
    // Active copies follow pending continuously while disabled, else only at wrap.
    swap     = !enable_q || wrap;
    wdog_run = enable_q && wdog_en_q;

    enable_d      = enable_q;
    wdog_en_d     = wdog_en_q;
    period_pend_d = period_pend_q;
    period_act_d  = period_act_q;
    prescale_d    = prescale_q;
    duty_pend_d   = duty_pend_q;
    duty_act_d    = duty_act_q;
    presc_d       = presc_q;
    cnt_d         = cnt_q;
    wdog_d        = wdog_q;
    failsafe_d    = failsafe_q;
    upd_d         = upd_q;
    pwm_d         = '0;

    if (wr_ctrl) begin
      enable_d  = bus.writedata[0];
      wdog_en_d = bus.writedata[1];
    end
    if (wr_prescale) begin
      prescale_d = bus.writedata[15:0];
    end

    if (!enable_q || wr_prescale || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 16'd1;
    end

    if (!enable_q || wrap) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 16'd1;
    end

    if (swap) begin
      period_act_d = period_pend_q;
      duty_act_d   = duty_pend_q;
      upd_d        = 1'b0;
    end
    // A write landing on the swap cycle stays pending for the next swap.
    if (wr_period) begin
      period_pend_d = bus.writedata[15:0];
      upd_d         = 1'b1;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (wr_duty[i]) begin
        duty_pend_d[i] = bus.writedata[15:0];
        upd_d          = 1'b1;
      end
    end

    // Duty write beats expiry in the same cycle.
    if (!wdog_run || duty_wr_any) begin
      wdog_d     = '0;
      failsafe_d = 1'b0;
    end else if (wdog_q == WdogMax) begin
      failsafe_d = 1'b1;
    end else begin
      wdog_d = wdog_q + WdogW'(1);
    end

    for (int i = 0; i < N_CH; i++) begin
      pwm_d[i] = enable_q && (cnt_q < duty_eff[i]);
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      4'd0:    bus.readdata = {30'd0, wdog_en_q, enable_q};
      4'd1:    bus.readdata = {16'd0, period_pend_q};
      4'd2:    bus.readdata = {16'd0, prescale_q};
      4'd3:    bus.readdata = {30'd0, upd_q, failsafe_q};
      default: begin
        for (int i = 0; i < N_CH; i++) begin
          if (bus.address == 4'(8 + i)) begin
            bus.readdata = {16'd0, duty_pend_q[i]};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q      <= 1'b0;
      wdog_en_q     <= 1'b0;
      period_pend_q <= '0;
      period_act_q  <= '0;
      prescale_q    <= '0;
      duty_pend_q   <= '0;
      duty_act_q    <= '0;
      presc_q       <= '0;
      cnt_q         <= '0;
      wdog_q        <= '0;
      failsafe_q    <= 1'b0;
      upd_q         <= 1'b0;
      pwm_q         <= '0;
    end else begin
      enable_q      <= enable_d;
      wdog_en_q     <= wdog_en_d;
      period_pend_q <= period_pend_d;
      period_act_q  <= period_act_d;
      prescale_q    <= prescale_d;
      duty_pend_q   <= duty_pend_d;
      duty_act_q    <= duty_act_d;
      presc_q       <= presc_d;
      cnt_q         <= cnt_d;
      wdog_q        <= wdog_d;
      failsafe_q    <= failsafe_d;
      upd_q         <= upd_d;
      pwm_q         <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: doc/nios_security_pwm_ctrl.md
NIOS_SECURITY_PWM_CTRL -- requirements
Module: nios_security_pwm_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of PWM channels (1..8).
REQ-002 SHALL have parameter WDOG_CYCLES, default 1000000, clk cycles without a duty write before failsafe.
REQ-003 SHALL have parameter FS_DUTY, default 0, duty forced on all channels during failsafe.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port address  input  4  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port readdata  output  32  read data, combinational from address, zero wait states.
REQ-011 SHALL have port pwm_out  output  N_CH  registered PWM outputs.

Function
REQ-012 SHALL decode: 0 CTRL (bit0 enable, bit1 wdog_en); 1 PERIOD[15:0]; 2 PRESCALE[15:0]; 3 STATUS (bit0 failsafe, bit1 update_pending; RO); 8+i DUTY_i[15:0].
REQ-013 SHALL accept a write when chipselect=1 and write_n=0; unused bits ignored; reads of unmapped addresses SHALL return 0.
REQ-014 SHALL return the pending (last written) value on reads of PERIOD and DUTY_i, zero-extended to 32 bits.
REQ-015 SHALL count prescaler 0..PRESCALE and assert one-cycle tick when prescaler==PRESCALE (PRESCALE=0 -> tick every cycle).
REQ-016 SHALL advance period counter cnt on tick, wrapping PERIOD->0; cnt=0 while enable=0.
REQ-017 SHALL hold active period/duty copies; writes to PERIOD/DUTY_i update pending copies only and set update_pending.
REQ-018 SHALL copy pending->active and clear update_pending on the tick where cnt==PERIOD (wrap), or on every cycle while enable=0.
REQ-019 SHALL drive pwm_out[i] next cycle as enable && (cnt < duty_eff[i]), duty_eff = FS_DUTY if failsafe else active DUTY_i.
REQ-020 SHALL yield constant high when duty_eff > PERIOD, constant low when duty_eff=0; PERIOD=0 -> high iff duty_eff>0.
REQ-021 SHALL run watchdog counter while enable and wdog_en; reset it on any DUTY_i write; set failsafe when it reaches WDOG_CYCLES-1.
REQ-022 SHALL clear failsafe only on a DUTY_i write or enable/wdog_en cleared; DUTY write in same cycle as expiry SHALL win (no failsafe).
REQ-023 SHALL on write to PRESCALE reset prescaler to 0; on PERIOD change at swap where cnt would exceed new PERIOD, cnt SHALL restart at 0.
REQ-024 SHALL on enable 1->0 drive all pwm_out low the next cycle; on 0->1 start with cnt=0, prescaler=0.

Reset
REQ-025 SHALL on reset_n=0 immediately clear CTRL, PERIOD, PRESCALE, all DUTY (pending and active), counters, failsafe, update_pending, and pwm_out to 0.
REQ-026 SHALL resume from all-zero state on first clk edge after reset_n deasserts; reset mid-period SHALL abandon the period with no glitch high.

Verification
REQ-027 PRESCALE=0, PERIOD=9, DUTY0=3, enable -> pwm_out[0] high 3 cycles, low 7, repeating period 10.
REQ-028 Mid-period write DUTY0=7 -> current period keeps 3-high; next period 7-high; STATUS.update_pending=1 until wrap.
REQ-029 DUTY1=0 and DUTY2=20 with PERIOD=9 -> pwm_out[1] constant low, pwm_out[2] constant high.
REQ-030 WDOG_CYCLES=100, wdog_en=1, no DUTY writes -> STATUS.failsafe=1 after 100 cycles, outputs at FS_DUTY; DUTY0 write clears it.
REQ-031 PRESCALE=3, PERIOD=4, DUTY0=2 -> pwm_out[0] high 8 clk, low 12 clk.
REQ-032 Assert reset_n=0 mid-high pulse -> pwm_out=0 and all registers read 0 without waiting for clk.
